dcmp_mem_writer: RTL

- Multi-channel successor to the two-input memory manager and address-select logic that sits between the decompressors and a single-port RAM.
- Accepts decoded words from NCH decompressor channels and buffers each in its own FIFO.
- Round-robin arbitrates the channels onto one RAM write port.
- Generates per-channel auto-incrementing addresses from programmable base/length windows, replacing hard-wired A/B/U/T addresses.

---
 rtl/dcmp_mem_writer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/dcmp_mem_writer.sv
// dcmp_mem_writer: buffers decoded words from NCH decompressor channels in
// per-channel FIFOs and round-robins them onto one registered RAM write port.
// Each channel writes into its own programmable base/length address window,
// wrapping at the end of the window and flagging ch_done on every wrap.
module dcmp_mem_writer #(
  parameter int N     = 32,
  parameter int NCH   = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          in_valid,
  input  logic [NCH*N-1:0]        in_data,
  output logic [NCH-1:0]          in_ready,
  input  logic                    cfg_we,
  input  logic [$clog2(NCH)-1:0]  cfg_ch,
  input  logic [AW-1:0]           cfg_base,
  input  logic [AW-1:0]           cfg_len,
  input  logic                    mem_stall,
  output logic                    mem_we,
  output logic [AW-1:0]           mem_addr,
  output logic [N-1:0]            mem_data,
  output logic [NCH-1:0]          ch_done,
  output logic                    busy
);

  localparam int CW = $clog2(NCH);
  localparam int PW = $clog2(DEPTH);

  // per-channel FIFO storage and bookkeeping
  logic [N-1:0]  fifo_mem [NCH][DEPTH];
  logic [PW-1:0] wr_ptr   [NCH];
  logic [PW-1:0] rd_ptr   [NCH];
  logic [PW:0]   count    [NCH];

  // per-channel address window
  logic [AW-1:0] base_r   [NCH];
  logic [AW-1:0] len_r    [NCH];
  logic [AW-1:0] offset_r [NCH];

  logic [NCH-1:0] fifo_empty;
  logic [NCH-1:0] fifo_full;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic [NCH-1:0] cfg_hit;
  logic [NCH-1:0] cand;

  // rr_ptr is where the next search starts (last grant + 1)
  logic [CW-1:0] rr_ptr;
  logic [CW-1:0] grant_idx;
  logic          grant_valid;
  logic [AW-1:0] grant_addr;
  logic [N-1:0]  grant_data;

  // FIFO status, accept decision and arbitration candidates
  always_comb begin
    fifo_empty = '0;
    fifo_full  = '0;
    push       = '0;
    cfg_hit    = '0;
    cand       = '0;
    for (int k = 0; k < NCH; k++) begin
      fifo_empty[k] = (count[k] == '0);
      fifo_full[k]  = (count[k] == (PW+1)'(DEPTH));
      // a channel being reconfigured sits out arbitration this cycle
      cfg_hit[k]    = cfg_we && (cfg_ch == CW'(k));
      push[k]       = in_valid[k] && !fifo_full[k];
      cand[k]       = !fifo_empty[k] && !cfg_hit[k];
    end
  end

  assign in_ready = ~fifo_full;
  assign busy     = (|(~fifo_empty)) || mem_we;

  // round-robin search starting at rr_ptr; nothing is granted while stalled
  always_comb begin
    logic [CW-1:0] scan;
    scan        = rr_ptr;
    grant_valid = 1'b0;
    grant_idx   = rr_ptr;
    pop         = '0;
    if (!mem_stall) begin
      for (int i = 0; i < NCH; i++) begin
        if (!grant_valid && cand[scan]) begin
          grant_valid = 1'b1;
          grant_idx   = scan;
        end
        scan = (scan == CW'(NCH-1)) ? '0 : scan + CW'(1);
      end
    end
    if (grant_valid) begin
      pop[grant_idx] = 1'b1;
    end
  end

  // write address is truncated to AW bits so windows wrap around the RAM
  always_comb begin
    grant_addr = base_r[grant_idx] + offset_r[grant_idx];
    grant_data = fifo_mem[grant_idx][rd_ptr[grant_idx]];
  end

  // FIFO storage; contents need no reset because the pointers gate them
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (push[k]) begin
        fifo_mem[k][wr_ptr[k]] <= in_data[k*N +: N];
      end
    end
  end

  // FIFO pointers and occupancy; reset drops any buffered words
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (push[k]) begin
          wr_ptr[k] <= wr_ptr[k] + PW'(1);
        end
        if (pop[k]) begin
          rd_ptr[k] <= rd_ptr[k] + PW'(1);
        end
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + (PW+1)'(1);
          2'b01:   count[k] <= count[k] - (PW+1)'(1);
          default: count[k] <= count[k];
        endcase
      end
    end
  end

  // window registers, offset advance and sticky done; config wins over a grant
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_done <= '0;
      for (int k = 0; k < NCH; k++) begin
        base_r[k]   <= '0;
        len_r[k]    <= '0;
        offset_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (cfg_hit[k]) begin
          base_r[k]   <= cfg_base;
          len_r[k]    <= cfg_len;
          offset_r[k] <= '0;
          ch_done[k]  <= 1'b0;
        end else if (pop[k]) begin
          // len of 0 means a full 2^AW window: len-1 wraps to all ones
          if (offset_r[k] == len_r[k] - AW'(1)) begin
            offset_r[k] <= '0;
            ch_done[k]  <= 1'b1;
          end else begin
            offset_r[k] <= offset_r[k] + AW'(1);
          end
        end
      end
    end
  end

  // registered RAM port and round-robin pointer; both freeze under stall
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      rr_ptr   <= '0;
    end else if (!mem_stall) begin
      mem_we <= grant_valid;
      if (grant_valid) begin
        mem_addr <= grant_addr;
        mem_data <= grant_data;
        rr_ptr   <= (grant_idx == CW'(NCH-1)) ? '0 : grant_idx + CW'(1);
      end
    end
  end

endmodule
